encoder_8to3_seq: RTL and testbench
===================================

Name: encoder_8to3_seq

Overview:
Registered 8-to-3 priority encoder with request capture and a valid/ready output handshake. It is the inverse of the team's 3-to-8 decoder. Eight request lines d0..d7 are captured into a pending register, and one encoded index is presented at a time. A downstream consumer accepts it, so no request is lost while the output stalls. It sits between event/request sources and any unit that consumes a 3-bit select code.

Parameters:
EDGE_MODE, 1, 1 = capture rising edges of d; 0 = capture level (pending |= d every cycle)
PRIO_HIGH, 1, fixed-priority order: 1 = d7 highest / d0 lowest; 0 = d0 highest / d7 lowest

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
d  input  8  request lines; bit i = request i
ready  input  1  consumer accepts code this cycle when valid && ready
valid  output  1  code holds a captured request
code  output  3  binary index of the presented request
multi  output  1  at least one other request was still pending when code was loaded
ovf  output  1  one-cycle pulse: a capture hit a bit already pending, so the request was lost

Behaviour:
- Reset (async assert, sync release): pending=0, d_q=0, valid=0, code=0, multi=0, ovf=0, state IDLE.
- Because d_q resets to 0, a d bit held high through reset is captured as an edge on the first clock after release.
- Capture, evaluated each clock edge:
  - EDGE_MODE=1: rise = d & ~d_q, and d_q <= d.
  - EDGE_MODE=0: rise = d.
  - pending_next = (pending & ~clr) | rise, where clr is the one-hot bit of the index loaded this cycle (0 if none).
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- ovf = |(rise & pending & ~clr), registered and high for exactly one cycle.
  - In EDGE_MODE=0, ovf is forced to 0, since held levels re-assert by design.
- Selection: sel = highest-priority set bit of pending, per PRIO_HIGH. Selection uses the registered pending, not the same-cycle rise.
- State machine:
  - IDLE (valid=0): if pending != 0, load code=sel, clr=onehot(sel), multi=(popcount(pending) > 1), valid<=1, go to PRESENT.
  - PRESENT (valid=1): code and multi are held stable while ready=0.
  - PRESENT on ready=1: if (pending & ~clr) != 0, load the next sel back-to-back and stay in PRESENT. Otherwise valid<=0 and go to IDLE.
  - Throughput is one accepted code per cycle under continuous ready.
- Latency: request sampled high at edge k, pending set at edge k, valid=1 with the code after edge k+1 (two edges).
- valid never drops without an accept, except on reset.
- Reset mid-PRESENT discards the presented code and all pending requests.
- ready while valid=0 is ignored.

Optional Feature:
ROUND_ROBIN_EN
- Defined: rotating priority. After each accepted code c, the highest priority moves to index (c+1) mod 8. Search wraps 7->0. PRIO_HIGH is ignored. The pointer resets to 0, so d0 has highest priority first.
- Undefined: fixed priority per PRIO_HIGH. No pointer register is built.

Test Plan:
- Reset then single request: EDGE_MODE=1, d=8'h10 for 1 cycle, ready=1 -> valid=1 with code=3'd4, multi=0 two edges later. valid=1 for one cycle, then IDLE.
- Simultaneous requests with stall: d=8'hA5 for 1 cycle, ready=0 for 5 cycles, then ready=1. Expected with PRIO_HIGH=1:
  - code=7, multi=1, held stable through the stall;
  - then 5, 2, 0 on consecutive cycles;
  - then valid=0.
- Overflow: d bit3 pulsed at cycles 0 and 2 while ready=0 and code 3 is not yet loaded -> ovf pulses once. Only one code 3 is delivered. A pulse arriving after code 3 is loaded produces a second code 3 and no ovf.
- Set/clear collision: bit 6 re-rises on the same edge it is loaded into code -> code 6 is delivered twice and ovf=0.
- Async reset mid-operation: assert rst for half a cycle while valid=1 with pending=8'h0F -> valid, code, multi, ovf and pending are immediately 0. Nothing is emitted after release until a new edge arrives.
- ROUND_ROBIN_EN defined: d=8'hFF held, EDGE_MODE=0, ready=1 -> codes 0,1,2,...,7,0 in consecutive cycles with multi=1.

Source files
------------

// File: rtl/encoder_8to3_seq.sv
// encoder_8to3_seq: registered 8-to-3 priority encoder with request capture and valid/ready output.
// Define ROUND_ROBIN_EN for rotating priority (pointer moves past each accepted code).
module encoder_8to3_seq #(
  parameter int EDGE_MODE = 1,
  parameter int PRIO_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] code,
  output logic       multi,
  output logic       ovf
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d, dq_q, rise, clr;
  logic [2:0] code_q, code_d, sel;
  logic       multi_q, multi_d, ovf_q, ovf_d, accept, load;
`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d, base;
  // On an accept the rotated priority must already apply to the back-to-back load.
  always_comb begin
    sel = '0;
    base = accept ? code_q + 3'd1 : ptr_q;
    for (int k = 7; k >= 0; k--) if (pend_q[base + 3'(k)]) sel = base + 3'(k);
  end
  assign ptr_d = accept ? code_q + 3'd1 : ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
`else
  logic [2:0] idx;
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      idx = PRIO_HIGH != 0 ? 3'(i) : 3'(7 - i);
      if (pend_q[idx]) sel = idx;
    end
  end
`endif
  assign rise   = EDGE_MODE != 0 ? d & ~dq_q : d;
  assign accept = state_q == PRESENT && ready;
  assign load   = |pend_q && (state_q == IDLE || accept);
  // The loaded bit leaves pending immediately; a same-edge rise re-sets it.
  always_comb begin
    clr     = load ? 8'b1 << sel : '0;
    pend_d  = (pend_q & ~clr) | rise;
    ovf_d   = EDGE_MODE != 0 && |(rise & pend_q & ~clr);
    code_d  = load ? sel : code_q;
    multi_d = load ? $countones(pend_q) > 1 : multi_q;
    state_d = load ? PRESENT : accept ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      dq_q    <= '0;
      code_q  <= '0;
      multi_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dq_q    <= d;
      code_q  <= code_d;
      multi_q <= multi_d;
      ovf_q   <= ovf_d;
    end
  assign valid = state_q == PRESENT;
  assign code  = code_q;
  assign multi = multi_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb_encoder_8to3_seq: directed vector table plus reset and round-robin sequences.
module tb_encoder_8to3_seq;
`ifdef ROUND_ROBIN_EN
  localparam int EM = 0;
`else
  localparam int EM = 1;
`endif
  typedef struct packed {
    logic [7:0] d;
    logic       rdy;
    logic       v;
    logic [2:0] c;
    logic       m;
    logic       o;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b1, ready = 1'b0;
  logic [7:0] d = '0;
  logic       valid, multi, ovf;
  logic [2:0] code;
  int         n_vec = 0, n_err = 0;
  vec_t       tbl[28];

  encoder_8to3_seq #(.EDGE_MODE(EM), .PRIO_HIGH(1)) dut (
    .clk(clk), .rst(rst), .d(d), .ready(ready),
    .valid(valid), .code(code), .multi(multi), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] c, input logic m, input logic o);
    chk({tag, " valid"}, 8'(valid), 8'(v));
    chk({tag, " ovf"}, 8'(ovf), 8'(o));
    if (v) begin
      chk({tag, " code"}, 8'(code), 8'(c));
      chk({tag, " multi"}, 8'(multi), 8'(m));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{8'h10, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0},
      '{8'hA5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0},
      '{8'h00, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0},
      '{8'h00, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0},
      '{8'h00, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0},
      '{8'h00, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0},
      '{8'h00, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0},
      '{8'h00, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0},
      '{8'h00, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0},
      '{8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0},
      '{8'h80, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0},
      '{8'h08, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0},
      '{8'h00, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0},
      '{8'h08, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1},
      '{8'h00, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0},
      '{8'h08, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0},
      '{8'hC0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0},
      '{8'h00, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0},
      '{8'h40, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0},
      '{8'h40, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0},
      '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 8'(valid), 8'h0);
    chk("reset code", 8'(code), 8'h0);
    chk("reset multi", 8'(multi), 8'h0);
    chk("reset ovf", 8'(ovf), 8'h0);
    #4 rst = 1'b0;
`ifdef ROUND_ROBIN_EN
    step();
    d = 8'hFF;
    ready = 1'b1;
    step();
    chk_out("rr capture", 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk_out($sformatf("rr cycle %0d", i), 1'b1, 3'(i % 8), 1'b1, 1'b0);
    end
`else
    for (int i = 0; i < 28; i++) begin
      d = tbl[i].d;
      ready = tbl[i].rdy;
      step();
      chk_out($sformatf("row %0d", i), tbl[i].v, tbl[i].c, tbl[i].m, tbl[i].o);
    end
    d = 8'h8F;
    ready = 1'b0;
    step();
    d = 8'h00;
    step();
    chk_out("pre-reset", 1'b1, 3'd7, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    chk("async valid", 8'(valid), 8'h0);
    chk("async code", 8'(code), 8'h0);
    chk("async multi", 8'(multi), 8'h0);
    chk("async ovf", 8'(ovf), 8'h0);
    #2 rst = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("post-reset idle %0d", i), 1'b0, 3'd0, 1'b0, 1'b0);
    end
    d = 8'h02;
    step();
    chk_out("new edge capture", 1'b0, 3'd0, 1'b0, 1'b0);
    d = 8'h00;
    step();
    chk_out("new edge present", 1'b1, 3'd1, 1'b0, 1'b0);
    step();
    chk_out("new edge drain", 1'b0, 3'd0, 1'b0, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
